write_master_2d: RTL and testbench

WRITE_MASTER_2D -- requirements
Module: write_master_2d

---
 rtl/write_master_2d.sv | 182 ++++++++++++++++++
 tb/tb_write_master_2d.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_master_2d.sv
// AXI4 write master that streams a FWFT FIFO into a 2D (row + stride) memory region.
// One burst in flight at a time; bursts are split at row ends and at 4 KB boundaries.
module write_master_2d #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_BURST_LEN  = 64
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            i_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   i_dst_addr,
  input  logic [31:0]                     i_img_width,
  input  logic [31:0]                     i_img_height,
  input  logic [31:0]                     i_img_stride,
  output logic                            o_write_done,
  output logic                            o_error,
  input  logic                            i_fifo_empty,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_fifo_data,
  output logic                            o_fifo_pop,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                      m_axi_awlen,
  output logic [2:0]                      m_axi_awsize,
  output logic [1:0]                      m_axi_awburst,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wlast,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  localparam int          AW        = C_M_AXI_ADDR_WIDTH;
  localparam logic [31:0] MAX_BYTES = 32'(C_M_AXI_BURST_LEN * 4);

  state_t        r_state, w_state_next;
  logic [AW-1:0] r_cur_addr, r_line_start, w_new_addr;
  logic [31:0]   r_line_done, r_bytes, r_row, r_width, r_height, r_stride;
  logic [7:0]    r_awlen, r_beat, w_awlen;
  logic          r_done, r_error;
  logic [31:0]   w_new_line_done, w_width_sel, w_rem, w_bnd, w_bytes;
  logic          w_load, w_line_end, w_last_row, w_w_hs, w_b_hs;

  assign m_axi_awaddr  = r_cur_addr;
  assign m_axi_awlen   = r_awlen;
  assign m_axi_awsize  = 3'b010;
  assign m_axi_awburst = 2'b01;
  assign m_axi_wstrb   = '1;
  assign m_axi_wdata   = i_fifo_data;
  assign o_write_done  = r_done;
  assign o_error       = r_error;

  always_comb begin
    w_state_next    = r_state;
    w_load          = 1'b0;
    w_new_addr      = r_cur_addr;
    w_new_line_done = r_line_done;
    w_width_sel     = r_width;
    m_axi_awvalid   = 1'b0;
    m_axi_wvalid    = 1'b0;
    m_axi_wlast     = 1'b0;
    m_axi_bready    = 1'b0;
    w_line_end      = (r_line_done + r_bytes) >= r_width;
    w_last_row      = (r_row == (r_height - 32'd1));

    case (r_state)
      S_IDLE: begin
        w_width_sel     = i_img_width;
        w_new_addr      = i_dst_addr;
        w_new_line_done = 32'd0;
        if (i_start && (i_img_width != 32'd0) && (i_img_height != 32'd0)) begin
          w_state_next = S_ADDR;
          w_load       = 1'b1;
        end
      end
      S_ADDR: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) w_state_next = S_DATA;
      end
      S_DATA: begin
        m_axi_wvalid = !i_fifo_empty;
        m_axi_wlast  = (r_beat == r_awlen);
        if (!i_fifo_empty && m_axi_wready && m_axi_wlast) w_state_next = S_RESP;
      end
      S_RESP: begin
        m_axi_bready = 1'b1;
        if (w_line_end) begin
          w_new_addr      = r_line_start + AW'(r_stride);
          w_new_line_done = 32'd0;
        end else begin
          w_new_addr      = r_cur_addr + AW'(r_bytes);
          w_new_line_done = r_line_done + r_bytes;
        end
        if (m_axi_bvalid) begin
          if (w_line_end && w_last_row) begin
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_ADDR;
            w_load       = 1'b1;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    // Handshake outputs are forced low while reset is held so nothing is
    // accepted on the edge that abandons the transfer.
    if (!reset_n) begin
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_wlast   = 1'b0;
      m_axi_bready  = 1'b0;
    end
    w_w_hs     = m_axi_wvalid && m_axi_wready;
    w_b_hs     = m_axi_bready && m_axi_bvalid;
    o_fifo_pop = w_w_hs;

    // Next burst size: limited by max burst, bytes left in the row, and the 4 KB page.
    w_rem   = w_width_sel - w_new_line_done;
    w_bnd   = 32'h1000 - 32'(w_new_addr[11:0]);
    w_bytes = MAX_BYTES;
    if (w_rem < w_bytes) w_bytes = w_rem;
    if (w_bnd < w_bytes) w_bytes = w_bnd;
    w_awlen = w_bytes[9:2] - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cur_addr   <= '0;
      r_line_start <= '0;
      r_line_done  <= '0;
      r_bytes      <= '0;
      r_row        <= '0;
      r_width      <= '0;
      r_height     <= '0;
      r_stride     <= '0;
      r_awlen      <= '0;
      r_beat       <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && i_start) begin
        // A zero-sized request completes immediately without any AXI traffic.
        r_done  <= !w_load;
        r_error <= 1'b0;
        if (w_load) begin
          r_line_start <= i_dst_addr;
          r_row        <= '0;
          r_width      <= i_img_width;
          r_height     <= i_img_height;
          r_stride     <= i_img_stride;
        end
      end
      if (w_load || w_b_hs) begin
        r_cur_addr  <= w_new_addr;
        r_line_done <= w_new_line_done;
      end
      if (w_load) begin
        r_bytes <= w_bytes;
        r_awlen <= w_awlen;
        r_beat  <= '0;
      end
      if (w_w_hs) r_beat <= r_beat + 8'd1;
      if (w_b_hs) begin
        if (m_axi_bresp != 2'b00) r_error <= 1'b1;
        if (w_line_end) begin
          r_line_start <= w_new_addr;
          r_row        <= r_row + 32'd1;
        end
        if (w_state_next == S_IDLE) r_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_write_master_2d.sv
// Bench for write_master_2d: a burst-list/data-order model derived from the row/4 KB
// splitting rules, checked every cycle, plus literal burst expectations per scenario.
module tb_write_master_2d;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_start;
  logic [31:0] i_dst_addr, i_img_width, i_img_height, i_img_stride;
  logic        o_write_done, o_error;
  logic        i_fifo_empty;
  logic [31:0] i_fifo_data;
  logic        o_fifo_pop;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;

  always #5 clk = ~clk;

  write_master_2d dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_dst_addr(i_dst_addr),
    .i_img_width(i_img_width), .i_img_height(i_img_height), .i_img_stride(i_img_stride),
    .o_write_done(o_write_done), .o_error(o_error),
    .i_fifo_empty(i_fifo_empty), .i_fifo_data(i_fifo_data), .o_fifo_pop(o_fifo_pop),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  typedef struct { logic [31:0] addr; logic [7:0] len; } burst_t;

  burst_t      exp_q[$];
  burst_t      obs_q[$];
  logic [31:0] data_q[$];
  logic [31:0] fifo_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int aw_acc, w_bursts, b_done, pops_total, beat;
  int stall_at, stall_left, b_err_idx;
  bit rnd_ready, start_flag, rst_drive, job_active, err_model;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected bursts from the splitting rules: per row, carve min(256, row left, page left).
  task automatic build_model(input logic [31:0] dst, input logic [31:0] w,
                             input logic [31:0] h, input logic [31:0] stride, input int id);
    logic [31:0] line, done_b, addr, bytes, page_left;
    int          total;
    burst_t      b;
    exp_q.delete();
    total = 0;
    if (w != 0) begin
      for (int r = 0; r < int'(h); r++) begin
        line   = dst + stride * r;
        done_b = 0;
        while (done_b < w) begin
          addr      = line + done_b;
          page_left = 32'h1000 - (addr & 32'hFFF);
          bytes     = 256;
          if (w - done_b < bytes) bytes = w - done_b;
          if (page_left < bytes) bytes = page_left;
          b.addr = addr;
          b.len  = 8'(bytes / 4 - 1);
          exp_q.push_back(b);
          total += int'(bytes / 4);
          done_b += bytes;
        end
      end
    end
    data_q.delete();
    fifo_q.delete();
    for (int i = 0; i < total; i++) begin
      data_q.push_back({8'(id), 24'(i * 7 + 3)});
      fifo_q.push_back({8'(id), 24'(i * 7 + 3)});
    end
  endtask

  task automatic check_cycle();
    burst_t b;
    if (!reset_n) begin
      chk("rst_awvalid", m_axi_awvalid, 0);
      chk("rst_wvalid", m_axi_wvalid, 0);
      chk("rst_wlast", m_axi_wlast, 0);
      chk("rst_bready", m_axi_bready, 0);
      chk("rst_pop", o_fifo_pop, 0);
      return;
    end
    chk("pop_eq_whs", o_fifo_pop, m_axi_wvalid && m_axi_wready);
    chk("error_level", o_error, err_model);
    if (job_active) chk("done_level", o_write_done, b_done == exp_q.size());
    if (i_fifo_empty) chk("wvalid_when_empty", m_axi_wvalid, 0);
    if (m_axi_wvalid) chk("w_needs_open_burst", aw_acc > w_bursts, 1);
    if (m_axi_bready) chk("b_needs_wlast", w_bursts > b_done, 1);
    if (m_axi_awvalid) begin
      chk("aw_one_outstanding", aw_acc, b_done);
      chk("awsize", m_axi_awsize, 3'b010);
      chk("awburst", m_axi_awburst, 2'b01);
    end
    if (m_axi_awvalid && m_axi_awready) begin
      b.addr = m_axi_awaddr;
      b.len  = m_axi_awlen;
      obs_q.push_back(b);
      if (aw_acc < exp_q.size()) begin
        chk("awaddr", m_axi_awaddr, exp_q[aw_acc].addr);
        chk("awlen", m_axi_awlen, exp_q[aw_acc].len);
      end else begin
        chk("extra_burst", aw_acc, exp_q.size());
      end
      aw_acc++;
      beat = 0;
    end
    if (m_axi_wvalid && m_axi_wready) begin
      if (pops_total < data_q.size() && w_bursts < exp_q.size()) begin
        chk("wdata", m_axi_wdata, data_q[pops_total]);
        chk("wlast", m_axi_wlast, beat == int'(exp_q[w_bursts].len));
        chk("wstrb", m_axi_wstrb, 4'hF);
        if (beat == int'(exp_q[w_bursts].len)) w_bursts++;
      end else begin
        chk("extra_beat", pops_total, data_q.size());
      end
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pops_total++;
      beat++;
    end
    if (m_axi_bvalid && m_axi_bready) begin
      if (m_axi_bresp != 2'b00) err_model = 1'b1;
      b_done++;
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 ns later.
  task automatic cycle();
    @(negedge clk);
    reset_n       = !rst_drive;
    i_start       = start_flag;
    m_axi_awready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    m_axi_wready  = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    m_axi_bvalid  = (w_bursts > b_done);
    m_axi_bresp   = (b_done == b_err_idx) ? 2'b10 : 2'b00;
    if (stall_left > 0 && pops_total >= stall_at) begin
      i_fifo_empty = 1'b1;
      stall_left--;
    end else begin
      i_fifo_empty = (fifo_q.size() == 0);
    end
    i_fifo_data = (fifo_q.size() > 0) ? fifo_q[0] : 32'hDEAD_BEEF;
    #1;
    check_cycle();
  endtask

  task automatic do_reset();
    rst_drive = 1'b1;
    cycle();
    cycle();
    chk("rst_done", o_write_done, 0);
    chk("rst_error", o_error, 0);
    rst_drive  = 1'b0;
    err_model  = 1'b0;
    job_active = 1'b0;
    aw_acc = 0; w_bursts = 0; b_done = 0; pops_total = 0; beat = 0; stall_left = 0;
    fifo_q.delete();
  endtask

  task automatic run_job(input logic [31:0] dst, input logic [31:0] w, input logic [31:0] h,
                         input logic [31:0] stride, input int id, input bit rnd,
                         input int stall, input int err_idx, input int abort_at);
    bit fin;
    bit completed;
    build_model(dst, w, h, stride, id);
    obs_q.delete();
    aw_acc = 0; w_bursts = 0; b_done = 0; pops_total = 0; beat = 0;
    rnd_ready  = rnd;
    stall_at   = stall;
    stall_left = (stall >= 0) ? 5 : 0;
    b_err_idx  = err_idx;
    i_dst_addr = dst; i_img_width = w; i_img_height = h; i_img_stride = stride;
    start_flag = 1'b1;
    cycle();
    start_flag = 1'b0;
    err_model  = 1'b0;
    job_active = 1'b1;
    completed  = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      fin = (b_done == exp_q.size());
      cycle();
      if (abort_at >= 0 && pops_total >= abort_at) begin
        do_reset();
        return;
      end
      if (fin) begin
        completed = 1'b1;
        break;
      end
    end
    chk("job_completed", completed, 1);
    for (int c = 0; c < 3; c++) cycle();
    chk("burst_count", aw_acc, exp_q.size());
    chk("pop_count", pops_total, data_q.size());
    chk("done_final", o_write_done, 1);
    chk("error_final", o_error, (err_idx >= 0 && err_idx < exp_q.size()) ? 1 : 0);
    $display("job %0d: dst=0x%0h w=%0d h=%0d stride=%0d bursts=%0d pops=%0d done=%0b err=%0b",
             id, dst, w, h, stride, aw_acc, pops_total, o_write_done, o_error);
    job_active = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; i_start = 1'b0; i_dst_addr = '0; i_img_width = '0; i_img_height = '0;
    i_img_stride = '0; i_fifo_empty = 1'b1; i_fifo_data = '0; m_axi_awready = 1'b0;
    m_axi_wready = 1'b0; m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;
    rnd_ready = 0; start_flag = 0; rst_drive = 0; job_active = 0; err_model = 0;
    aw_acc = 0; w_bursts = 0; b_done = 0; pops_total = 0; beat = 0;
    stall_at = -1; stall_left = 0; b_err_idx = -1;

    do_reset();
    chk("reset_awvalid", m_axi_awvalid, 0);
    chk("reset_bready", m_axi_bready, 0);
    cycle();

    // Single full burst
    run_job(32'h1000, 256, 1, 256, 1, 0, -1, -1, -1);
    chk("j1_nbursts", obs_q.size(), 1);
    if (obs_q.size() == 1) begin
      chk("j1_addr", obs_q[0].addr, 32'h1000);
      chk("j1_len", obs_q[0].len, 63);
    end

    // 4 KB split
    run_job(32'h1F80, 512, 1, 512, 2, 0, -1, -1, -1);
    chk("model_j2_addr1", exp_q[1].addr, 32'h2000);
    chk("j2_nbursts", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      chk("j2_addr0", obs_q[0].addr, 32'h1F80);
      chk("j2_len0", obs_q[0].len, 31);
      chk("j2_addr1", obs_q[1].addr, 32'h2000);
      chk("j2_len1", obs_q[1].len, 63);
      chk("j2_addr2", obs_q[2].addr, 32'h2100);
      chk("j2_len2", obs_q[2].len, 31);
    end

    // Three short rows with stride
    run_job(32'h0, 16, 3, 640, 3, 0, -1, -1, -1);
    chk("j3_nbursts", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      chk("j3_addr0", obs_q[0].addr, 32'h0);
      chk("j3_addr1", obs_q[1].addr, 32'h280);
      chk("j3_addr2", obs_q[2].addr, 32'h500);
      chk("j3_len2", obs_q[2].len, 3);
    end

    // FIFO stall at beat 10 for 5 cycles, random ready
    run_job(32'h5000, 256, 1, 256, 4, 1, 10, -1, -1);

    // Error response on the first of two bursts
    run_job(32'h3000, 512, 1, 512, 5, 1, -1, 0, -1);
    chk("j5_nbursts", obs_q.size(), 2);

    // Zero width and zero height
    run_job(32'h100, 0, 5, 0, 6, 0, -1, -1, -1);
    run_job(32'h100, 64, 0, 64, 7, 0, -1, -1, -1);

    // Reset during DATA, then a fresh transfer
    run_job(32'h4000, 256, 2, 1024, 8, 0, -1, -1, 20);
    cycle();
    run_job(32'h8000, 64, 1, 64, 9, 0, -1, -1, -1);
    chk("j9_nbursts", obs_q.size(), 1);
    if (obs_q.size() == 1) begin
      chk("j9_addr", obs_q[0].addr, 32'h8000);
      chk("j9_len", obs_q[0].len, 15);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
